// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path: frame-checker
// state encoding plus the parity-type and stop-bit selector values.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic STP_ONE  = 1'b0;
    localparam logic STP_TWO  = 1'b1;

endpackage

// File: rtl/uart_rx_par_calc.sv
// Combinational parity generator, shared by the RX frame checker and the
// TX path: returns the parity bit a correct frame carries for the word.
module uart_rx_par_calc
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  par_bit
);

    // Even parity makes the total count of ones even; odd inverts that bit.
    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker: follows one frame (start, data, optional
// parity, one or two stop bits) from mid-bit samples and reports the word
// together with registered, mutually consistent error pulses at frame end.
// Optional feature: define ERR_CNT_EN to add saturating stop-error and
// parity-error counters (stp_err_cnt, par_err_cnt).
module uart_rx_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start_det,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STP_BITS,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  busy
`ifdef ERR_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt,
    output logic [CNT_WIDTH-1:0]  par_err_cnt
`endif
);

    localparam int CW = $clog2(DATA_WIDTH);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || CNT_WIDTH < 1) begin : g_bad_param
        $error("uart_rx_frame_check: DATA_WIDTH must be 5..9 and CNT_WIDTH >= 1");
    end

    rx_state_t             state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         bit_cnt;
    logic                  par_en_l;
    logic                  par_typ_l;
    logic                  stp_bits_l;
    logic                  par_fail;
    logic                  stp_fail;
    logic                  stp_idx;
    logic                  par_exp;
    logic                  stp_fail_nxt;
    logic                  stp_last;

    uart_rx_par_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_par_calc (
        .data    (shreg),
        .par_typ (par_typ_l),
        .par_bit (par_exp)
    );

    // Stop-fail including the sample being taken now, and whether that sample
    // is the last stop bit of the frame.
    assign stp_fail_nxt = stp_fail | ~sampled_bit;
    assign stp_last     = (stp_bits_l == STP_ONE) | stp_idx;

    // Data shift register: LSB arrives first, so each new bit enters at the MSB.
    always_ff @(posedge CLK) begin
        if (state == DATA && bit_valid) begin
            shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
        end
    end

    // Frame FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            par_en_l    <= 1'b0;
            par_typ_l   <= 1'b0;
            stp_bits_l  <= 1'b0;
            par_fail    <= 1'b0;
            stp_fail    <= 1'b0;
            stp_idx     <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
            busy        <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_det) begin
                        state      <= START;
                        par_en_l   <= PAR_EN;
                        par_typ_l  <= PAR_TYP;
                        stp_bits_l <= STP_BITS;
                        par_fail   <= 1'b0;
                        stp_fail   <= 1'b0;
                        stp_idx    <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (bit_valid) begin
                        if (!sampled_bit) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            strt_glitch <= 1'b1;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (bit_valid) begin
                        if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                            state <= par_en_l ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_valid) begin
                        par_fail <= (sampled_bit != par_exp);
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bit_valid) begin
                        if (stp_last) begin
                            par_err <= par_fail;
                            stp_err <= stp_fail_nxt;
                            if (!par_fail && !stp_fail_nxt) begin
                                P_DATA     <= shreg;
                                data_valid <= 1'b1;
                            end
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            stp_fail <= stp_fail_nxt;
                            stp_idx  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ERR_CNT_EN
    logic frame_done;

    assign frame_done = (state == STOP) && bit_valid && stp_last;

    // Saturating per-frame error counters, bumped at the frame-end edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stp_err_cnt <= '0;
            par_err_cnt <= '0;
        end else begin
            if (frame_done && stp_fail_nxt && stp_err_cnt != '1) begin
                stp_err_cnt <= stp_err_cnt + CNT_WIDTH'(1);
            end
            if (frame_done && par_fail && par_err_cnt != '1) begin
                par_err_cnt <= par_err_cnt + CNT_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Bench for uart_rx_frame_check: two instances (8-bit and 5-bit words),
// frame-level reference model feeding per-instance expectation queues,
// and negedge monitors that pop and compare on every output pulse.
module tb_uart_rx_frame_check;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic       sg;
        logic [8:0] pdata;
        int         cyc;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic start_det   [2];
    logic bit_valid   [2];
    logic sampled_bit [2];
    logic par_en      [2];
    logic par_typ     [2];
    logic stp_bits    [2];

    logic [7:0] pdata0;
    logic [4:0] pdata1;
    logic dv0, pe0, se0, sg0, bsy0;
    logic dv1, pe1, se1, sg1, bsy1;
`ifdef ERR_CNT_EN
    logic [7:0] scnt0, pcnt0, scnt1, pcnt1;
`endif

    uart_rx_frame_check #(.DATA_WIDTH(8), .CNT_WIDTH(8)) u_dut8 (
        .CLK (CLK), .RST (RST),
        .start_det (start_det[0]), .bit_valid (bit_valid[0]), .sampled_bit (sampled_bit[0]),
        .PAR_EN (par_en[0]), .PAR_TYP (par_typ[0]), .STP_BITS (stp_bits[0]),
        .P_DATA (pdata0), .data_valid (dv0), .par_err (pe0), .stp_err (se0),
        .strt_glitch (sg0), .busy (bsy0)
`ifdef ERR_CNT_EN
        , .stp_err_cnt (scnt0), .par_err_cnt (pcnt0)
`endif
    );

    uart_rx_frame_check #(.DATA_WIDTH(5), .CNT_WIDTH(8)) u_dut5 (
        .CLK (CLK), .RST (RST),
        .start_det (start_det[1]), .bit_valid (bit_valid[1]), .sampled_bit (sampled_bit[1]),
        .PAR_EN (par_en[1]), .PAR_TYP (par_typ[1]), .STP_BITS (stp_bits[1]),
        .P_DATA (pdata1), .data_valid (dv1), .par_err (pe1), .stp_err (se1),
        .strt_glitch (sg1), .busy (bsy1)
`ifdef ERR_CNT_EN
        , .stp_err_cnt (scnt1), .par_err_cnt (pcnt1)
`endif
    );

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [8:0] last_good [2];
    int   serr_n [2];
    int   perr_n [2];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int sel, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s [dut%0d]: got 0x%0h, expected 0x%0h", name,
                     (sel == 0) ? 8 : 5, act, exp);
        end
    endtask

    function automatic int sat(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    function automatic logic bsy(input int sel);
        return (sel == 0) ? bsy0 : bsy1;
    endfunction

    task automatic push_exp(input int sel, input exp_t e);
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Pop the oldest expectation for an instance and compare the pulse against it.
    task automatic mon(input int sel, input logic dv, input logic pe, input logic se,
                       input logic sg, input logic [8:0] pd, input logic b);
        exp_t e;
        if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
            chk("unexpected_pulse", sel, 32'({dv, pe, se, sg}), 0);
            return;
        end
        if (sel == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        chk("pulse_cycle", sel, cyc, e.cyc);
        chk("data_valid", sel, 32'(dv), 32'(e.dv));
        chk("par_err", sel, 32'(pe), 32'(e.pe));
        chk("stp_err", sel, 32'(se), 32'(e.se));
        chk("strt_glitch", sel, 32'(sg), 32'(e.sg));
        chk("p_data", sel, 32'(pd), 32'(e.pdata));
        chk("busy_fall", sel, 32'(b), 0);
`ifdef ERR_CNT_EN
        chk("stp_err_cnt", sel, 32'((sel == 0) ? scnt0 : scnt1), sat(serr_n[sel]));
        chk("par_err_cnt", sel, 32'((sel == 0) ? pcnt0 : pcnt1), sat(perr_n[sel]));
`endif
    endtask

    always @(negedge CLK) begin
        if (RST && (dv0 || pe0 || se0 || sg0)) mon(0, dv0, pe0, se0, sg0, {1'b0, pdata0}, bsy0);
    end

    always @(negedge CLK) begin
        if (RST && (dv1 || pe1 || se1 || sg1)) mon(1, dv1, pe1, se1, sg1, {4'b0, pdata1}, bsy1);
    end

    // One bit period: random idle gap, then a single bit_valid strobe.
    task automatic send_bit(input int sel, input logic b, input logic sd, output int c);
        repeat ($urandom_range(0, 3)) step();
        chk("busy_hold", sel, 32'(bsy(sel)), 1);
        bit_valid[sel]   = 1'b1;
        sampled_bit[sel] = b;
        start_det[sel]   = sd;
        c = cyc;
        step();
        bit_valid[sel]   = 1'b0;
        start_det[sel]   = 1'b0;
        sampled_bit[sel] = 1'($urandom);
    endtask

    // Drive one frame and record what a correct receiver must report for it.
    task automatic send_frame(input int sel, input logic [8:0] data, input logic pen,
                              input logic ptyp, input logic stp2, input logic glitch,
                              input logic pflip, input logic s0, input logic s1,
                              input logic toggle, input logic noise);
        int         w = (sel == 0) ? 8 : 5;
        int         c;
        exp_t       e;
        logic [8:0] m;
        logic       exp_par;
        logic       perr;
        logic       serr;
        m = data & ((9'd1 << w) - 9'd1);
        repeat ($urandom_range(0, 2)) step();
        par_en[sel]   = pen;
        par_typ[sel]  = ptyp;
        stp_bits[sel] = stp2;
        start_det[sel] = 1'b1;
        if (noise) begin
            bit_valid[sel]   = 1'b1;
            sampled_bit[sel] = 1'b1;
        end
        step();
        start_det[sel] = 1'b0;
        bit_valid[sel] = 1'b0;
        chk("busy_rise", sel, 32'(bsy(sel)), 1);
        if (toggle) begin
            par_en[sel]   = ~pen;
            par_typ[sel]  = ~ptyp;
            stp_bits[sel] = ~stp2;
        end
        send_bit(sel, glitch, 1'b0, c);
        if (glitch) begin
            e.dv = 1'b0; e.pe = 1'b0; e.se = 1'b0; e.sg = 1'b1;
            e.pdata = last_good[sel];
            e.cyc = c + 1;
            push_exp(sel, e);
            return;
        end
        for (int i = 0; i < w; i++) send_bit(sel, m[i], noise && (i == 2), c);
        perr = 1'b0;
        if (pen) begin
            exp_par = ((($countones(m) % 2) == 1) ? 1'b1 : 1'b0) ^ ptyp;
            perr = pflip;
            send_bit(sel, exp_par ^ pflip, 1'b0, c);
        end
        serr = !s0;
        send_bit(sel, s0, 1'b0, c);
        if (stp2) begin
            serr = serr || !s1;
            send_bit(sel, s1, 1'b0, c);
        end
        e.dv = !perr && !serr;
        e.pe = perr;
        e.se = serr;
        e.sg = 1'b0;
        if (e.dv) last_good[sel] = m;
        e.pdata = last_good[sel];
        e.cyc = c + 1;
        if (serr) serr_n[sel]++;
        if (perr) perr_n[sel]++;
        push_exp(sel, e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            step();
            n++;
        end
        chk("drain_timeout", 0, q0.size() + q1.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start_det[s] = 1'b0; bit_valid[s] = 1'b0; sampled_bit[s] = 1'b0;
            par_en[s] = 1'b0; par_typ[s] = 1'b0; stp_bits[s] = 1'b0;
            last_good[s] = '0; serr_n[s] = 0; perr_n[s] = 0;
        end
        repeat (3) step();
        chk("reset_p_data", 0, 32'(pdata0), 0);
        chk("reset_p_data", 1, 32'(pdata1), 0);
        chk("reset_pulses", 0, 32'({dv0, pe0, se0, sg0}), 0);
        chk("reset_pulses", 1, 32'({dv1, pe1, se1, sg1}), 0);
        chk("reset_busy", 0, 32'(bsy0), 0);
        chk("reset_busy", 1, 32'(bsy1), 0);
`ifdef ERR_CNT_EN
        chk("reset_cnt", 0, 32'({scnt0, pcnt0}), 0);
`endif
        RST = 1'b1;
        step();

        // Directed frames from the test plan.
        send_frame(0, 9'hA5, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        send_frame(0, 9'h03, 1, 0, 0, 0, 1, 1, 1, 0, 0);
        send_frame(0, 9'h5A, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        send_frame(0, 9'h00, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        send_frame(0, 9'h11, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        send_frame(1, 9'h1F, 1, 1, 0, 0, 0, 1, 1, 1, 0);
        wait_drain();
        chk("p_data_hold", 0, 32'(pdata0), 32'h11);
        chk("p_data_w5", 1, 32'(pdata1), 32'h1F);

        // Randomized frames on both widths.
        for (int k = 0; k < 60; k++) begin
            send_frame(k % 2, 9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
                       1'($urandom), ($urandom_range(0, 3) == 0));
        end
        wait_drain();

        // Reset in the middle of the data bits abandons the frame silently.
        begin
            int c;
            par_en[0] = 1'b0; stp_bits[0] = 1'b0;
            start_det[0] = 1'b1;
            step();
            start_det[0] = 1'b0;
            send_bit(0, 1'b0, 1'b0, c);
            for (int i = 0; i < 3; i++) send_bit(0, 1'($urandom), 1'b0, c);
            RST = 1'b0;
            step();
            chk("mid_reset_busy", 0, 32'(bsy0), 0);
            chk("mid_reset_p_data", 0, 32'(pdata0), 0);
            for (int s = 0; s < 2; s++) begin
                last_good[s] = '0; serr_n[s] = 0; perr_n[s] = 0;
            end
            RST = 1'b1;
            repeat (20) step();
            chk("post_reset_busy", 0, 32'(bsy0), 0);
            send_frame(0, 9'h3C, 0, 0, 0, 0, 0, 1, 1, 0, 0);
            wait_drain();
        end

`ifdef ERR_CNT_EN
        // Stop errors well past the counter range to exercise saturation.
        for (int k = 0; k < 260; k++) begin
            send_frame(0, 9'($urandom), 0, 0, 0, 0, 0, 0, 1, 0, 0);
        end
        wait_drain();
        chk("stp_err_cnt_sat", 0, 32'(scnt0), 255);
        chk("par_err_cnt_final", 0, 32'(pcnt0), sat(perr_n[0]));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
